// File: rtl/scv_pkg.sv
// Shared types and constants for the Super Cassette Vision core.
package scv_pkg;

    typedef enum logic [1:0] {S_IDLE, S_VID, S_CPU} arb_state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_VID, SRC_CPU} src_t;

    localparam int SCV_VRAM_AW = 13;

endpackage

// File: rtl/scv_vram_arb.sv
// Single-port VRAM arbiter: video fetch has priority, a starvation counter
// bounds CPU latency. One RAM access per clock, reads return two edges after grant.
module scv_vram_arb
    import scv_pkg::*;
#(
    parameter int AW           = SCV_VRAM_AW,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic          CLK,
    input  logic          RESETB,
    input  logic          CPU_RD,
    input  logic          CPU_WR,
    input  logic [AW-1:0] CPU_A,
    input  logic [7:0]    CPU_DI,
    output logic [7:0]    CPU_DO,
    output logic          CPU_WAIT,
    input  logic          VID_REQ,
    input  logic [AW-1:0] VID_A,
    output logic          VID_ACK,
    output logic [7:0]    VID_DO,
    output logic          VID_DV,
    output logic          RAM_CE,
    output logic          RAM_WE,
    output logic [AW-1:0] RAM_A,
    output logic [7:0]    RAM_DO,
    input  logic [7:0]    RAM_DI
);

    localparam int             CW   = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [CW-1:0]  WMAX = CW'(CPU_MAX_WAIT);

    arb_state_t    state_q, state_d;
    logic          strb_q, strb_d;
    logic          cpu_pend_q, cpu_pend_d;
    logic          cpu_we_q, cpu_we_d;
    logic [AW-1:0] cpu_a_q, cpu_a_d;
    logic [7:0]    cpu_d_q, cpu_d_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_a_q, ram_a_d;
    logic [7:0]    ram_do_q, ram_do_d;
    src_t          tag1_q, tag1_d, tag2_q, tag2_d;
    logic          rd_infl_q, rd_infl_d;
    logic [7:0]    cpu_do_q, cpu_do_d;
    logic [7:0]    vid_do_q, vid_do_d;
    logic          vid_dv_q, vid_dv_d;
    logic          rise;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q    <= S_IDLE;
            strb_q     <= 1'b0;
            cpu_pend_q <= 1'b0;
            cpu_we_q   <= 1'b0;
            cpu_a_q    <= '0;
            cpu_d_q    <= '0;
            wait_cnt_q <= '0;
            ram_we_q   <= 1'b0;
            ram_a_q    <= '0;
            ram_do_q   <= '0;
            tag1_q     <= SRC_NONE;
            tag2_q     <= SRC_NONE;
            rd_infl_q  <= 1'b0;
            cpu_do_q   <= '0;
            vid_do_q   <= '0;
            vid_dv_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            strb_q     <= strb_d;
            cpu_pend_q <= cpu_pend_d;
            cpu_we_q   <= cpu_we_d;
            cpu_a_q    <= cpu_a_d;
            cpu_d_q    <= cpu_d_d;
            wait_cnt_q <= wait_cnt_d;
            ram_we_q   <= ram_we_d;
            ram_a_q    <= ram_a_d;
            ram_do_q   <= ram_do_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag2_d;
            rd_infl_q  <= rd_infl_d;
            cpu_do_q   <= cpu_do_d;
            vid_do_q   <= vid_do_d;
            vid_dv_q   <= vid_dv_d;
        end
    end

    always_comb begin
        strb_d     = CPU_RD | CPU_WR;
        rise       = strb_d & ~strb_q;
        cpu_pend_d = cpu_pend_q;
        cpu_we_d   = cpu_we_q;
        cpu_a_d    = cpu_a_q;
        cpu_d_d    = cpu_d_q;
        wait_cnt_d = wait_cnt_q;
        ram_we_d   = 1'b0;
        ram_a_d    = ram_a_q;
        ram_do_d   = ram_do_q;
        tag1_d     = SRC_NONE;
        tag2_d     = tag1_q;
        rd_infl_d  = rd_infl_q;
        cpu_do_d   = cpu_do_q;
        vid_do_d   = vid_do_q;
        vid_dv_d   = 1'b0;

        // A starved CPU access overrides the video stream.
        if (cpu_pend_q && wait_cnt_q == WMAX) state_d = S_CPU;
        else if (VID_REQ)                     state_d = S_VID;
        else if (cpu_pend_q)                  state_d = S_CPU;
        else                                  state_d = S_IDLE;

        case (state_d)
            S_VID: begin
                ram_a_d = VID_A;
                tag1_d  = SRC_VID;
            end
            S_CPU: begin
                ram_a_d  = cpu_a_q;
                ram_do_d = cpu_d_q;
                ram_we_d = cpu_we_q;
                tag1_d   = cpu_we_q ? SRC_NONE : SRC_CPU;
            end
            default: ;
        endcase

        if (state_d == S_CPU)
            wait_cnt_d = '0;
        else if (cpu_pend_q && wait_cnt_q != WMAX)
            wait_cnt_d = wait_cnt_q + CW'(1);

        // A new strobe edge while an access is still pending is dropped.
        if (cpu_pend_q) begin
            if (state_d == S_CPU) cpu_pend_d = 1'b0;
        end else if (rise) begin
            cpu_pend_d = 1'b1;
            cpu_we_d   = CPU_WR;
            cpu_a_d    = CPU_A;
            cpu_d_d    = CPU_DI;
        end

        if (tag2_q == SRC_VID) begin
            vid_dv_d = 1'b1;
            vid_do_d = RAM_DI;
        end
        if (tag2_q == SRC_CPU) begin
            cpu_do_d  = RAM_DI;
            rd_infl_d = 1'b0;
        end
        if (state_d == S_CPU && !cpu_we_q) rd_infl_d = 1'b1;
    end

    assign VID_ACK  = RESETB & (state_d == S_VID);
    assign CPU_WAIT = cpu_pend_q | rd_infl_q;
    assign CPU_DO   = cpu_do_q;
    assign VID_DO   = vid_do_q;
    assign VID_DV   = vid_dv_q;
    assign RAM_CE   = (state_q != S_IDLE);
    assign RAM_WE   = ram_we_q;
    assign RAM_A    = ram_a_q;
    assign RAM_DO   = ram_do_q;

endmodule

// File: tb/tb_scv_vram_arb.sv
// Bench for scv_vram_arb: directed timing sequences, a table of CPU accesses,
// and a randomized run against a transaction-level reference model.
module tb_scv_vram_arb;

    localparam int MAXW = 4;

    logic        CLK = 1'b0;
    logic        RESETB;
    logic        CPU_RD, CPU_WR;
    logic [12:0] CPU_A;
    logic [7:0]  CPU_DI, CPU_DO;
    logic        CPU_WAIT;
    logic        VID_REQ;
    logic [12:0] VID_A;
    logic        VID_ACK;
    logic [7:0]  VID_DO;
    logic        VID_DV;
    logic        RAM_CE, RAM_WE;
    logic [12:0] RAM_A;
    logic [7:0]  RAM_DO, RAM_DI;

    int checks = 0;
    int errors = 0;

    scv_vram_arb #(.AW(13), .CPU_MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .RESETB(RESETB),
        .CPU_RD(CPU_RD), .CPU_WR(CPU_WR), .CPU_A(CPU_A), .CPU_DI(CPU_DI),
        .CPU_DO(CPU_DO), .CPU_WAIT(CPU_WAIT),
        .VID_REQ(VID_REQ), .VID_A(VID_A), .VID_ACK(VID_ACK),
        .VID_DO(VID_DO), .VID_DV(VID_DV),
        .RAM_CE(RAM_CE), .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_DO(RAM_DO),
        .RAM_DI(RAM_DI)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM, 1-cycle read latency, with a bench-side preload port.
    logic [7:0]  mem [0:8191];
    logic        pl_en = 1'b0;
    logic [12:0] pl_a = '0;
    logic [7:0]  pl_d = '0;
    always @(posedge CLK) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (RAM_CE) begin
            if (RAM_WE) mem[RAM_A] <= RAM_DO;
            else        RAM_DI <= mem[RAM_A];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [12:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        tick;
        pl_en = 1'b0;
    endtask

    task automatic do_reset;
        RESETB = 1'b0;
        tick;
        RESETB = 1'b1;
        tick;
    endtask

    // Holds the strobe for the whole access and a few cycles after, so a
    // long strobe must still produce only one RAM access.
    task automatic cpu_access(input logic rd, input logic wr, input logic [12:0] a,
                              input logic [7:0] d, output logic saw_we, output int n_ce);
        logic done;
        CPU_RD = rd; CPU_WR = wr; CPU_A = a; CPU_DI = d;
        n_ce = 0; saw_we = 1'b0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick;
            if (RAM_CE) begin n_ce++; saw_we = RAM_WE; end
            if (!CPU_WAIT) done = 1'b1;
        end
        if (!done) chk("cpu_access_timeout", 32'd0, 32'd1);
        repeat (3) begin
            tick;
            if (RAM_CE) n_ce++;
        end
        CPU_RD = 1'b0; CPU_WR = 1'b0;
        tick;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [12:0] a;
        logic [7:0]  d;
        logic        exp_we;
        logic [7:0]  exp_do;
    } vec_t;
    vec_t vecs [8];

    typedef struct {
        int         due;
        bit         cpu;
        logic [7:0] data;
    } ret_t;

    initial begin
        logic        we_seen, ack, cg, dvseen;
        int          nce, acks, dvcnt;
        logic [7:0]  got [8];
        int          dvc [8];
        logic [7:0]  ref_mem [16];
        ret_t        rq [$];
        ret_t        r;
        int          k, g, m_cnt;
        bit          m_pend, m_we, m_prev, pend_old, rise, strb, exp_dv, cpu_q;
        logic [3:0]  m_a;
        logic [7:0]  m_d, m_cpu_do, exp_vdo;
        logic [12:0] exp_ra;

        vecs[0] = '{1'b1, 1'b0, 13'h0123, 8'h00, 1'b0, 8'h5A};
        vecs[1] = '{1'b0, 1'b1, 13'h1FFF, 8'hC3, 1'b1, 8'h5A};
        vecs[2] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 1'b0, 8'hC3};
        vecs[3] = '{1'b1, 1'b1, 13'h0040, 8'h3C, 1'b1, 8'hC3};
        vecs[4] = '{1'b1, 1'b0, 13'h0040, 8'h00, 1'b0, 8'h3C};
        vecs[5] = '{1'b0, 1'b1, 13'h0000, 8'hFF, 1'b1, 8'h3C};
        vecs[6] = '{1'b1, 1'b0, 13'h0000, 8'h00, 1'b0, 8'hFF};
        vecs[7] = '{1'b1, 1'b0, 13'h0123, 8'h00, 1'b0, 8'h5A};

        RESETB = 1'b0; CPU_RD = 1'b0; CPU_WR = 1'b0; CPU_A = '0; CPU_DI = '0;
        VID_REQ = 1'b1; VID_A = 13'h0005;
        tick; tick;
        chk("reset_outputs", {CPU_DO, CPU_WAIT, VID_DO, VID_DV, VID_ACK,
                              RAM_CE, RAM_WE, RAM_A, RAM_DO}, '0);
        VID_REQ = 1'b0;
        RESETB = 1'b1;
        tick;
        preload(13'h0123, 8'h5A);
        preload(13'h0200, 8'h69);

        // Plain CPU read; strobe drops before grant and must not cancel it.
        CPU_RD = 1'b1; CPU_A = 13'h0123;
        tick;
        chk("rd_pend_wait", CPU_WAIT, 1'b1);
        chk("rd_pend_ce", RAM_CE, 1'b0);
        CPU_RD = 1'b0;
        tick;
        chk("rd_grant_ce", {RAM_CE, RAM_WE, RAM_A}, {1'b1, 1'b0, 13'h0123});
        chk("rd_grant_wait", CPU_WAIT, 1'b1);
        tick;
        chk("rd_sample_ce", RAM_CE, 1'b0);
        chk("rd_sample_wait", CPU_WAIT, 1'b1);
        tick;
        chk("rd_data", CPU_DO, 8'h5A);
        chk("rd_done_wait", CPU_WAIT, 1'b0);
        tick;

        for (int i = 0; i < 8; i++) begin
            cpu_access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, we_seen, nce);
            chk($sformatf("vec%0d_we", i), we_seen, vecs[i].exp_we);
            chk($sformatf("vec%0d_one_ce", i), nce, 1);
            chk($sformatf("vec%0d_cpu_do", i), CPU_DO, vecs[i].exp_do);
        end

        // Video stream: eight accesses back to back, data in address order.
        for (int i = 0; i < 8; i++) preload(13'(i), 8'hA0 + 8'(i));
        VID_A = '0; VID_REQ = 1'b1; acks = 0; dvcnt = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge CLK);
            ack = VID_ACK;
            tick;
            if (VID_DV) begin
                if (dvcnt < 8) begin got[dvcnt] = VID_DO; dvc[dvcnt] = c; end
                dvcnt++;
            end
            if (ack) begin
                acks++;
                VID_A = VID_A + 13'd1;
                if (acks == 8) VID_REQ = 1'b0;
            end
        end
        chk("vid_dv_count", dvcnt, 8);
        chk("vid_first_dv", dvc[0], 2);
        for (int i = 0; i < 8 && i < dvcnt; i++) begin
            chk($sformatf("vid_data%0d", i), got[i], 8'hA0 + 8'(i));
            chk($sformatf("vid_nogap%0d", i), dvc[i], dvc[0] + i);
        end

        // Starvation: CPU wins exactly on the fifth edge after pend is set.
        VID_A = 13'h0001; VID_REQ = 1'b1;
        tick; tick;
        CPU_RD = 1'b1; CPU_A = 13'h0200;
        tick;
        chk("starve_pend", CPU_WAIT, 1'b1);
        CPU_RD = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge CLK);
            ack = VID_ACK;
            tick;
            cg = RAM_CE && !RAM_WE && RAM_A == 13'h0200;
            chk($sformatf("starve_ack%0d", j), ack, j != 5);
            chk($sformatf("starve_cpu%0d", j), cg, j == 5);
        end
        chk("starve_data", {CPU_WAIT, CPU_DO}, {1'b0, 8'h69});
        VID_REQ = 1'b0;
        tick; tick; tick;

        // Randomized run against the reference model.
        do_reset;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'($urandom);
            preload(13'(i), ref_mem[i]);
        end
        k = 0; m_cnt = 0; m_pend = 0; m_we = 0; m_prev = 0; m_a = '0; m_d = '0;
        m_cpu_do = '0; exp_vdo = '0;
        for (int n = 0; n < 420; n++) begin
            if (n < 400) begin
                CPU_RD  = ($urandom_range(0, 3) == 0);
                CPU_WR  = ($urandom_range(0, 5) == 0);
                CPU_A   = 13'($urandom_range(0, 15));
                CPU_DI  = 8'($urandom);
                VID_REQ = ($urandom_range(0, 9) < 6);
                VID_A   = 13'($urandom_range(0, 15));
            end else begin
                CPU_RD = 1'b0; CPU_WR = 1'b0; VID_REQ = 1'b0;
            end
            if (m_pend && m_cnt == MAXW) g = 2;
            else if (VID_REQ)           g = 1;
            else if (m_pend)            g = 2;
            else                        g = 0;
            @(negedge CLK);
            chk("rnd_vid_ack", VID_ACK, g == 1);
            tick;
            k++;
            exp_dv = 0;
            while (rq.size() > 0 && rq[0].due == k) begin
                r = rq.pop_front();
                if (r.cpu) m_cpu_do = r.data;
                else begin exp_dv = 1; exp_vdo = r.data; end
            end
            exp_ra = '0;
            if (g == 1) begin
                exp_ra = VID_A;
                r.due = k + 2; r.cpu = 0; r.data = ref_mem[VID_A[3:0]];
                rq.push_back(r);
            end else if (g == 2) begin
                exp_ra = {9'd0, m_a};
                if (m_we) ref_mem[m_a] = m_d;
                else begin
                    r.due = k + 2; r.cpu = 1; r.data = ref_mem[m_a];
                    rq.push_back(r);
                end
            end
            pend_old = m_pend;
            strb = CPU_RD | CPU_WR;
            rise = strb && !m_prev;
            if (g == 2) begin m_pend = 0; m_cnt = 0; end
            else if (pend_old && m_cnt < MAXW) m_cnt++;
            if (!pend_old && rise) begin
                m_pend = 1; m_we = CPU_WR; m_a = CPU_A[3:0]; m_d = CPU_DI;
            end
            m_prev = strb;
            cpu_q = 0;
            foreach (rq[i]) if (rq[i].cpu) cpu_q = 1;
            chk("rnd_ram_ce", RAM_CE, g != 0);
            chk("rnd_ram_we", RAM_WE, g == 2 && m_we);
            if (g != 0) chk("rnd_ram_a", RAM_A, exp_ra);
            chk("rnd_vid_dv", VID_DV, exp_dv);
            if (exp_dv) chk("rnd_vid_do", VID_DO, exp_vdo);
            chk("rnd_cpu_do", CPU_DO, m_cpu_do);
            chk("rnd_cpu_wait", CPU_WAIT, m_pend || cpu_q);
        end
        for (int i = 0; i < 16; i++) chk($sformatf("rnd_mem%0d", i), mem[i], ref_mem[i]);

        // Reset between grant and data return discards the video read.
        VID_A = 13'h0003; VID_REQ = 1'b1;
        @(negedge CLK);
        chk("mid_ack", VID_ACK, 1'b1);
        tick;
        chk("mid_grant", RAM_CE, 1'b1);
        RESETB = 1'b0;
        #1;
        chk("mid_reset_outputs", {CPU_DO, CPU_WAIT, VID_DO, VID_DV, VID_ACK,
                                  RAM_CE, RAM_WE, RAM_A, RAM_DO}, '0);
        tick; tick;
        RESETB = 1'b1; VID_REQ = 1'b0;
        dvseen = 1'b0;
        repeat (4) begin
            tick;
            dvseen |= VID_DV;
        end
        chk("mid_no_dv", dvseen, 1'b0);
        VID_REQ = 1'b1;
        tick;
        VID_REQ = 1'b0;
        tick; tick;
        chk("resume_vid", {VID_DV, VID_DO}, {1'b1, ref_mem[3]});
        cpu_access(1'b1, 1'b0, 13'h0123, 8'h00, we_seen, nce);
        chk("resume_cpu", {nce[1:0], CPU_DO}, {2'd1, 8'h5A});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
